// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame buffer arbiter: writer FSM encoding,
// index-width helper and default geometry constants.
package frame_buf_pkg;

    typedef logic [0:0] wr_state_t;

    localparam wr_state_t W_IDLE   = 1'b0;
    localparam wr_state_t W_ACTIVE = 1'b1;

    localparam int unsigned     DEFAULT_ADDR_BITS    = 24;
    localparam longint unsigned DEFAULT_FRAME_STRIDE = 2073600;

    // A single-bit index is kept even for tiny counts so port widths never collapse to zero.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buf_pick.sv
// Combinational next-buffer selection: first index after the current one that
// is neither held by the reader nor holding the newest completed frame.
module frame_buf_pick #(
    parameter int unsigned BUF_NUM = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [IDX_W-1:0] cur_idx_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [IDX_W-1:0] last_done_i,
    input  logic             last_valid_i,
    output logic [IDX_W-1:0] next_idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        next_idx_o = cur_idx_i;
        cand       = '0;
        found      = 1'b0;
        // Candidates walk forward from cur+1 and wrap back to cur itself last.
        for (int unsigned k = 1; k <= BUF_NUM; k++) begin
            cand = IDX_W'((32'(cur_idx_i) + k) % BUF_NUM);
            if (!found && (cand != rd_idx_i) && !(last_valid_i && (cand == last_done_i))) begin
                next_idx_o = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Triple/multi-buffer arbiter between one frame writer and one frame reader,
// handing out buffer indices and base addresses with one-cycle grant latency.
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int unsigned     BUF_NUM      = 4,
    parameter int unsigned     ADDR_BITS    = DEFAULT_ADDR_BITS,
    parameter longint unsigned FRAME_STRIDE = DEFAULT_FRAME_STRIDE,
    parameter longint unsigned BASE_ADDR    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_buf_req,
    input  logic                        wr_frame_done,
    input  logic                        rd_buf_req,
    input  logic                        freeze,
    output logic                        wr_buf_valid,
    output logic [idx_w(BUF_NUM)-1:0]   wr_buf_idx,
    output logic [ADDR_BITS-1:0]        wr_buf_addr,
    output logic                        rd_buf_valid,
    output logic [idx_w(BUF_NUM)-1:0]   rd_buf_idx,
    output logic [ADDR_BITS-1:0]        rd_buf_addr,
    output logic                        rd_frame_valid,
    output logic [15:0]                 drop_cnt
);

    localparam int unsigned     IDX_W     = idx_w(BUF_NUM);
    localparam longint unsigned LAST_BASE = BASE_ADDR + 64'(BUF_NUM - 1) * FRAME_STRIDE;
    localparam logic [ADDR_BITS-1:0] BASE_TRUNC = ADDR_BITS'(BASE_ADDR);

    if (BUF_NUM < 3 || BUF_NUM > 8) begin : g_bad_buf_num
        $error("frame_buf_arbiter: BUF_NUM must be within 3..8");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 64 || (LAST_BASE >> ADDR_BITS) != 64'd0) begin : g_bad_addr
        $error("frame_buf_arbiter: buffer address range does not fit in ADDR_BITS");
    end

    function automatic logic [ADDR_BITS-1:0] buf_addr(input logic [IDX_W-1:0] idx);
        logic [63:0] full;
        full = BASE_ADDR + 64'(idx) * FRAME_STRIDE;
        return full[ADDR_BITS-1:0];
    endfunction

    wr_state_t        wr_state_q, wr_state_d, state_mid;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] last_done_q, last_done_d;
    logic             last_valid_q, last_valid_d;
    logic             last_seen_q, last_seen_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             drop_inc, abort;
    logic [IDX_W-1:0] pick_idx;

    logic                 wr_buf_valid_q, rd_buf_valid_q, rd_frame_valid_q;
    logic [IDX_W-1:0]     wr_buf_idx_q, rd_buf_idx_q;
    logic [ADDR_BITS-1:0] wr_buf_addr_q, rd_buf_addr_q;

    // Completion is resolved first so a same-cycle read sees the fresh frame.
    always_comb begin
        state_mid    = wr_state_q;
        last_done_d  = last_done_q;
        last_valid_d = last_valid_q;
        last_seen_d  = last_seen_q;
        rd_idx_d     = rd_idx_q;
        drop_inc     = 1'b0;
        if (wr_frame_done && (wr_state_q == W_ACTIVE)) begin
            state_mid = W_IDLE;
            if (freeze) begin
                drop_inc = 1'b1;
            end else begin
                drop_inc     = last_valid_q && !last_seen_q;
                last_done_d  = wr_idx_q;
                last_valid_d = 1'b1;
                last_seen_d  = 1'b0;
            end
        end
        if (rd_buf_req) begin
            rd_idx_d    = last_done_d;
            last_seen_d = 1'b1;
        end
    end

    frame_buf_pick #(
        .BUF_NUM (BUF_NUM),
        .IDX_W   (IDX_W)
    ) u_pick (
        .cur_idx_i    (wr_idx_q),
        .rd_idx_i     (rd_idx_d),
        .last_done_i  (last_done_d),
        .last_valid_i (last_valid_d),
        .next_idx_o   (pick_idx)
    );

    always_comb begin
        wr_state_d = state_mid;
        wr_idx_d   = wr_idx_q;
        abort      = 1'b0;
        if (wr_buf_req) begin
            abort      = (state_mid == W_ACTIVE);
            wr_state_d = W_ACTIVE;
            wr_idx_d   = pick_idx;
        end
        drop_cnt_d = drop_cnt_q;
        if ((drop_inc || abort) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q       <= W_IDLE;
            wr_idx_q         <= '0;
            rd_idx_q         <= '0;
            last_done_q      <= '0;
            last_valid_q     <= 1'b0;
            last_seen_q      <= 1'b0;
            drop_cnt_q       <= '0;
            wr_buf_valid_q   <= 1'b0;
            wr_buf_idx_q     <= '0;
            wr_buf_addr_q    <= BASE_TRUNC;
            rd_buf_valid_q   <= 1'b0;
            rd_buf_idx_q     <= '0;
            rd_buf_addr_q    <= BASE_TRUNC;
            rd_frame_valid_q <= 1'b0;
        end else begin
            wr_state_q     <= wr_state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            last_done_q    <= last_done_d;
            last_valid_q   <= last_valid_d;
            last_seen_q    <= last_seen_d;
            drop_cnt_q     <= drop_cnt_d;
            wr_buf_valid_q <= wr_buf_req;
            rd_buf_valid_q <= rd_buf_req;
            if (wr_buf_req) begin
                wr_buf_idx_q  <= wr_idx_d;
                wr_buf_addr_q <= buf_addr(wr_idx_d);
            end
            if (rd_buf_req) begin
                rd_buf_idx_q     <= rd_idx_d;
                rd_buf_addr_q    <= buf_addr(rd_idx_d);
                rd_frame_valid_q <= last_valid_d;
            end
        end
    end

    assign wr_buf_valid   = wr_buf_valid_q;
    assign wr_buf_idx     = wr_buf_idx_q;
    assign wr_buf_addr    = wr_buf_addr_q;
    assign rd_buf_valid   = rd_buf_valid_q;
    assign rd_buf_idx     = rd_buf_idx_q;
    assign rd_buf_addr    = rd_buf_addr_q;
    assign rd_frame_valid = rd_frame_valid_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: doc/frame_buf_arbiter.md
FRAME_BUF_ARBITER -- requirements
Module: frame_buf_arbiter

Interface
REQ-001 Parameter BUF_NUM, default 4, frame buffer count; legal range 3..8.
REQ-002 Parameter ADDR_BITS, default 24, memory address width.
REQ-003 Parameter FRAME_STRIDE, default 2073600, word distance between buffer base addresses.
REQ-004 Parameter BASE_ADDR, default 0, base address of buffer 0.
REQ-005 clk  input  1  single clock, the memory clock domain; all ports are synchronous to it.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_buf_req  input  1  one-cycle pulse: writer starts a frame and requests a buffer.
REQ-008 wr_frame_done  input  1  one-cycle pulse: writer has completed the current frame.
REQ-009 rd_buf_req  input  1  one-cycle pulse: reader starts a frame and requests the newest complete buffer.
REQ-010 freeze  input  1  level: while high, completed frames are discarded and the displayed image holds.
REQ-011 wr_buf_valid, rd_buf_valid  output  1 each  one-cycle grant strobes.
REQ-012 wr_buf_idx, rd_buf_idx  output  IDX_W each  granted buffer index; IDX_W = clog2(BUF_NUM).
REQ-013 wr_buf_addr, rd_buf_addr  output  ADDR_BITS each  granted base address.
REQ-014 rd_frame_valid  output  1  high when the reader grant refers to a completed frame.
REQ-015 drop_cnt  output  16  saturating count of lost frames.

Function
REQ-016 Writer FSM has two states: W_IDLE and W_ACTIVE; wr_buf_req moves it to W_ACTIVE, and wr_frame_done in W_ACTIVE returns it to W_IDLE.
REQ-017 wr_frame_done received in W_IDLE is ignored.
REQ-018 On wr_buf_req, the writer index is the first of wr_idx+1, wr_idx+2, ... (mod BUF_NUM) that is neither the reader index nor, when last_valid=1, last_done.
REQ-019 On wr_frame_done in W_ACTIVE with freeze=0, last_done is set to wr_idx and last_valid to 1.
REQ-020 If that completion overwrites a valid frame the reader has never been granted, drop_cnt increments.
REQ-021 On wr_frame_done in W_ACTIVE with freeze=1, last_done is unchanged and drop_cnt increments.
REQ-022 wr_buf_req received in W_ACTIVE aborts the current frame: drop_cnt increments, a new index is selected per REQ-018, and the FSM stays in W_ACTIVE.
REQ-023 On rd_buf_req, the reader index is last_done and rd_frame_valid equals last_valid; the reader holds that index until its next rd_buf_req.
REQ-024 Same-cycle priority order is: wr_frame_done, then rd_buf_req, then wr_buf_req.
REQ-025 Under REQ-024, a reader request sees a completion arriving in the same cycle, and the writer's exclusion uses the reader index just updated in that cycle.
REQ-026 Grant latency is one cycle: valid, idx, addr and rd_frame_valid are registered, and idx/addr hold between grants.
REQ-027 addr = BASE_ADDR + idx*FRAME_STRIDE, truncated to ADDR_BITS.
REQ-028 Elaboration fails if BUF_NUM is outside 3..8 or if BASE_ADDR+(BUF_NUM-1)*FRAME_STRIDE does not fit in ADDR_BITS.
REQ-029 drop_cnt saturates at 16'hFFFF.

Reset
REQ-030 rst forces: writer FSM to W_IDLE; wr_idx, rd_idx and last_done to 0; last_valid to 0; all valids to 0; idx and addr outputs to 0 and BASE_ADDR respectively; drop_cnt to 0.
REQ-031 Reset mid-frame discards all buffer ownership without counting a drop.

Structure
REQ-032 A shared package frame_buf_pkg holds the writer FSM state typedef, a clog2-based IDX_W helper and the default FRAME_STRIDE/ADDR_BITS constants.
REQ-033 Next-index selection is a combinational sub-module, frame_buf_pick, with inputs current index, reader index, last_done and last_valid, and output the next index.

Verification (BUF_NUM=4, STRIDE=2073600, BASE=0)
REQ-034 Reset then rd_buf_req -> next cycle rd_buf_valid=1, rd_buf_idx=0, rd_buf_addr=0, rd_frame_valid=0.
REQ-035 wr_buf_req -> wr_buf_idx=1, addr=2073600; then wr_frame_done, rd_buf_req -> rd_buf_idx=1, rd_frame_valid=1.
REQ-036 Reader holding 1; run writer frames req/done x4 -> wr_buf_idx sequence 2,3,0,2 (1 skipped); drop_cnt=3.
REQ-037 wr_frame_done and rd_buf_req in the same cycle, writer on idx 2 -> rd_buf_idx=2.
REQ-038 Same cycle also carrying wr_buf_req -> writer index avoids 2, giving 3.
REQ-039 freeze=1 during a completed frame -> rd_buf_idx unchanged on next rd_buf_req, drop_cnt+1; a double wr_buf_req -> drop_cnt+1, new index granted.
REQ-040 rst asserted while W_ACTIVE on idx 3 -> all outputs at reset values; first wr_buf_req afterwards -> wr_buf_idx=1.
